// File: rtl/pipelined_int_alu_pkg.sv
// Shared types for the pipelined integer ALU: operation codes and the flag bundle.
// Port summary: none (package only).
package pipelined_int_alu_pkg;

  localparam int unsigned CODE_WIDTH = 4;

  // Operation codes; any code outside this list executes as AND.
  typedef enum logic [CODE_WIDTH-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9
  } int_alu_code_e;

  // Adder flags; both are zero for everything except ADD and SUB.
  typedef struct packed {
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/pipelined_int_alu_core.sv
// Combinational integer datapath: shared adder with operand inversion, logic ops,
// signed/unsigned compare and barrel shifts.
// Ports: code_i (operation), op_a_i/op_b_i (operands), result_o, flags_o (carry/overflow).
module pipelined_int_alu_core
  import pipelined_int_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [CODE_WIDTH-1:0] code_i,
  input  logic [DATA_WIDTH-1:0] op_a_i,
  input  logic [DATA_WIDTH-1:0] op_b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output alu_flags_t            flags_o
);

  localparam int unsigned MSB     = DATA_WIDTH - 1;
  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

  int_alu_code_e         code;
  logic                  is_sub;
  logic [DATA_WIDTH-1:0] b_eff;
  logic [DATA_WIDTH:0]   sum_ext;
  logic [DATA_WIDTH-1:0] sum;
  logic                  carry;
  logic                  ovf;
  logic [SHAMT_W-1:0]    shamt;

  assign code = int_alu_code_e'(code_i);

  always_comb begin
    // Compares reuse the subtractor: SLT from sign^overflow, SLTU from borrow.
    is_sub   = (code == OP_SUB) || (code == OP_SLT) || (code == OP_SLTU);
    b_eff    = is_sub ? ~op_b_i : op_b_i;
    sum_ext  = {1'b0, op_a_i} + {1'b0, b_eff} + (DATA_WIDTH+1)'(is_sub);
    sum      = sum_ext[DATA_WIDTH-1:0];
    carry    = sum_ext[DATA_WIDTH];
    ovf      = (sum[MSB] ^ op_a_i[MSB]) & (sum[MSB] ^ b_eff[MSB]);
    shamt    = op_b_i[SHAMT_W-1:0];
    result_o = op_a_i & op_b_i;
    flags_o  = '0;
    case (code)
      OP_ADD, OP_SUB: begin
        result_o         = sum;
        flags_o.carry    = carry;
        flags_o.overflow = ovf;
      end
      OP_AND:  result_o = op_a_i & op_b_i;
      OP_OR:   result_o = op_a_i | op_b_i;
      OP_XOR:  result_o = op_a_i ^ op_b_i;
      OP_SLT:  result_o = DATA_WIDTH'(sum[MSB] ^ ovf);
      OP_SLTU: result_o = DATA_WIDTH'(!carry);
      OP_SLL:  result_o = op_a_i << shamt;
      OP_SRL:  result_o = op_a_i >> shamt;
      OP_SRA:  result_o = DATA_WIDTH'($signed(op_a_i) >>> shamt);
      default: result_o = op_a_i & op_b_i;
    endcase
  end

endmodule

// File: rtl/pipelined_int_alu.sv
// Back-pressurable pipelined integer ALU. Compute happens in front of stage 0;
// later stages only re-register. Each stage loads when empty or when it drains,
// so bubbles collapse even while the output is stalled.
// Ports: clk, rst (sync, active-low), flush; input handshake inValid/inReady with
// inCode/inOpA/inOpB/inTag; output handshake outValid/outReady with
// outData/outCarry/outOverflow/outTag, all driven from last-stage registers.
module pipelined_int_alu
  import pipelined_int_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [CODE_WIDTH-1:0] inCode,
  input  logic [DATA_WIDTH-1:0] inOpA,
  input  logic [DATA_WIDTH-1:0] inOpB,
  input  logic [TAG_WIDTH-1:0]  inTag,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outCarry,
  output logic                  outOverflow,
  output logic [TAG_WIDTH-1:0]  outTag
);

  localparam int unsigned LAST = PIPE_STAGES - 1;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    alu_flags_t            flags;
    logic [TAG_WIDTH-1:0]  tag;
  } stage_t;

  stage_t                 stage_q [PIPE_STAGES];
  stage_t                 stage_d [PIPE_STAGES];
  stage_t                 in_stage;
  logic [PIPE_STAGES-1:0] ready_c;
  logic                   rdy;
  logic [DATA_WIDTH-1:0]  alu_result;
  alu_flags_t             alu_flags;

  pipelined_int_alu_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .code_i  (inCode),
    .op_a_i  (inOpA),
    .op_b_i  (inOpB),
    .result_o(alu_result),
    .flags_o (alu_flags)
  );

  // Ready ripples from the output back to the input: a stage can take a new op
  // if it is empty or everything downstream of it can move.
  always_comb begin
    ready_c = '0;
    rdy     = outReady;
    for (int k = int'(LAST); k >= 0; k--) begin
      rdy        = !stage_q[k].valid | rdy;
      ready_c[k] = rdy;
    end
  end

  // Next-state for every stage; data is only overwritten by a valid upstream op.
  always_comb begin
    stage_d  = stage_q;
    in_stage = '{valid: inValid, data: alu_result, flags: alu_flags, tag: inTag};
    if (ready_c[0]) begin
      stage_d[0].valid = in_stage.valid;
      if (in_stage.valid) stage_d[0] = in_stage;
    end
    for (int k = 1; k < int'(PIPE_STAGES); k++) begin
      if (ready_c[k]) begin
        stage_d[k].valid = stage_q[k-1].valid;
        if (stage_q[k-1].valid) stage_d[k] = stage_q[k-1];
      end
    end
    // Flush wins over any load, including the op offered this cycle.
    if (flush) begin
      for (int k = 0; k < int'(PIPE_STAGES); k++) stage_d[k].valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < int'(PIPE_STAGES); k++) stage_q[k] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign inReady     = ready_c[0];
  assign outValid    = stage_q[LAST].valid;
  assign outData     = stage_q[LAST].data;
  assign outCarry    = stage_q[LAST].flags.carry;
  assign outOverflow = stage_q[LAST].flags.overflow;
  assign outTag      = stage_q[LAST].tag;

endmodule

// File: tb/tb_pipelined_int_alu.sv
module tb_pipelined_int_alu;
  import pipelined_int_alu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 6;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          carry;
    logic          ovf;
    logic [TW-1:0] tag;
  } res_t;

  typedef struct packed {
    logic [3:0]    code;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] d;
    logic          c;
    logic          v;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          flush = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [3:0]    in_code = '0;
  logic [DW-1:0] in_a = '0, in_b = '0, out_data;
  logic [TW-1:0] in_tag = '0, out_tag;
  logic          out_carry, out_ovf;

  logic          flush3 = 1'b0, in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b0;
  logic [3:0]    in_code3 = '0;
  logic [DW-1:0] in_a3 = '0, in_b3 = '0, out_data3;
  logic [TW-1:0] in_tag3 = '0, out_tag3;
  logic          out_carry3, out_ovf3;

  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];
  res_t exp_q3[$];

  always #5 clk = ~clk;

  pipelined_int_alu #(.DATA_WIDTH(DW), .PIPE_STAGES(2), .TAG_WIDTH(TW)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .inValid(in_valid), .inReady(in_ready),
    .inCode(in_code), .inOpA(in_a), .inOpB(in_b), .inTag(in_tag),
    .outValid(out_valid), .outReady(out_ready), .outData(out_data),
    .outCarry(out_carry), .outOverflow(out_ovf), .outTag(out_tag)
  );

  pipelined_int_alu #(.DATA_WIDTH(DW), .PIPE_STAGES(3), .TAG_WIDTH(TW)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush3), .inValid(in_valid3), .inReady(in_ready3),
    .inCode(in_code3), .inOpA(in_a3), .inOpB(in_b3), .inTag(in_tag3),
    .outValid(out_valid3), .outReady(out_ready3), .outData(out_data3),
    .outCarry(out_carry3), .outOverflow(out_ovf3), .outTag(out_tag3)
  );

  // Independent reference: 33-bit arithmetic and sign-rule overflow.
  function automatic res_t model(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [TW-1:0] t);
    logic [DW:0] s;
    res_t r;
    r = '0;
    r.tag = t;
    case (c)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r.data = s[DW-1:0]; r.carry = s[DW];
        r.ovf = (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
      end
      4'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.data = s[DW-1:0]; r.carry = s[DW];
        r.ovf = (a[DW-1] != b[DW-1]) && (s[DW-1] != a[DW-1]);
      end
      4'd3: r.data = a | b;
      4'd4: r.data = a ^ b;
      4'd5: r.data = {31'd0, $signed(a) < $signed(b)};
      4'd6: r.data = {31'd0, a < b};
      4'd7: r.data = a << b[4:0];
      4'd8: r.data = a >> b[4:0];
      4'd9: r.data = 32'($signed(a) >>> b[4:0]);
      default: r.data = a & b;
    endcase
    return r;
  endfunction

  // One cycle on the 2-stage unit: drive after negedge, sample 1 time unit later.
  task automatic step(input logic iv, input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [TW-1:0] t, input logic ordy, input logic fl, input res_t e,
                      output logic acc, output logic pop, output res_t o);
    @(negedge clk);
    in_valid = iv; in_code = c; in_a = a; in_b = b; in_tag = t; out_ready = ordy; flush = fl;
    #1;
    acc = iv && in_ready && !fl && rst;
    pop = out_valid && ordy;
    o   = {out_data, out_carry, out_ovf, out_tag};
    if (acc) exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_carry, out_ovf, out_tag} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b d=%h c=%b o=%b t=%h expected all zero",
               out_valid, out_data, out_carry, out_ovf, out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if ({out_valid3, out_data3, out_tag3} !== '0) begin
      failures++; $display("FAIL reset_outputs_p3: got v=%b d=%h t=%h expected zero", out_valid3, out_data3, out_tag3);
    end
    rst = 1'b1;
  endtask

  task automatic test_latency(input string name);
    logic acc, pop;
    res_t o, e;
    int lat;
    lat = -1;
    step(1'b1, 4'(OP_ADD), 32'hFFFF_FFFF, 32'h1, 6'd5, 1'b1, 1'b0, res_t'{32'h0, 1'b1, 1'b0, 6'd5}, acc, pop, o);
    checks++;
    if (!acc) begin failures++; $display("FAIL %s_accept: got 0 expected 1", name); end
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      step(1'b0, 4'd0, '0, '0, '0, 1'b1, 1'b0, '0, acc, pop, o);
      if (pop) begin
        lat = i;
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin failures++; $display("FAIL %s_value: got %h expected %h", name, o, e); end
      end
    end
    checks++;
    if (lat != 2) begin failures++; $display("FAIL %s_cycles: got %0d expected 2", name, lat); end
  endtask

  task automatic test_ops();
    op_t tbl[13];
    logic acc, pop;
    res_t o, e;
    int i;
    tbl = '{
      '{4'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1},
      '{4'd5, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0},
      '{4'd6, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0},
      '{4'd9, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0, 1'b0},
      '{4'd7, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0},
      '{4'd8, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0},
      '{4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1},
      '{4'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0},
      '{4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0},
      '{4'd3, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 1'b0},
      '{4'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0},
      '{4'd15, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678, 1'b0, 1'b0},
      '{4'd5, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0}
    };
    i = 0;
    for (int cyc = 0; cyc < 60 && (i < 13 || exp_q.size() > 0); cyc++) begin
      if (i < 13)
        step(1'b1, tbl[i].code, tbl[i].a, tbl[i].b, 6'(10 + i), 1'b1, 1'b0,
             res_t'{tbl[i].d, tbl[i].c, tbl[i].v, 6'(10 + i)}, acc, pop, o);
      else
        step(1'b0, 4'd0, '0, '0, '0, 1'b1, 1'b0, '0, acc, pop, o);
      if (acc) i++;
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL ops_extra: got unexpected %h", o);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin failures++; $display("FAIL ops_result: got %h expected %h", o, e); end
        end
      end
    end
    checks++;
    if (i != 13 || exp_q.size() != 0) begin
      failures++; $display("FAIL ops_drain: got sent=%0d pending=%0d expected 13/0", i, exp_q.size());
    end
  endtask

  task automatic test_back_pressure();
    logic [3:0] c[6];
    logic [DW-1:0] a[6], b[6];
    logic acc, pop, stable, have_prev;
    res_t o, e, prev;
    int i, pops;
    for (int k = 0; k < 6; k++) begin
      c[k] = 4'($urandom_range(0, 9)); a[k] = $urandom; b[k] = $urandom;
    end
    i = 0; stable = 1'b1; have_prev = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step(1'b1, c[i], a[i], b[i], 6'(40 + i), 1'b0, 1'b0, model(c[i], a[i], b[i], 6'(40 + i)), acc, pop, o);
      if (acc) i++;
      if (out_valid) begin
        if (have_prev && o !== prev) stable = 1'b0;
        prev = o; have_prev = 1'b1;
      end
    end
    checks++;
    if (i != 2) begin failures++; $display("FAIL bp_accepts: got %0d expected 2", i); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    checks++;
    if (!stable || !have_prev) begin
      failures++; $display("FAIL bp_stable: got stable=%b seen=%b expected 1/1", stable, have_prev);
    end
    pops = 0;
    for (int cyc = 0; cyc < 40 && (i < 6 || exp_q.size() > 0); cyc++) begin
      if (i < 6)
        step(1'b1, c[i], a[i], b[i], 6'(40 + i), 1'b1, 1'b0, model(c[i], a[i], b[i], 6'(40 + i)), acc, pop, o);
      else
        step(1'b0, 4'd0, '0, '0, '0, 1'b1, 1'b0, '0, acc, pop, o);
      if (acc) i++;
      if (pop) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL bp_extra: got unexpected %h", o);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin failures++; $display("FAIL bp_order: got %h expected %h", o, e); end
        end
      end
    end
    checks++;
    if (pops != 6 || exp_q.size() != 0) begin
      failures++; $display("FAIL bp_count: got pops=%0d pending=%0d expected 6/0", pops, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic acc, pop, iv, ordy;
    logic [3:0] c;
    logic [DW-1:0] a, b;
    logic [TW-1:0] t;
    res_t o, e;
    for (int cyc = 0; cyc < 340; cyc++) begin
      iv   = (cyc < 300) && ($urandom_range(0, 3) != 0);
      ordy = (cyc >= 300) || ($urandom_range(0, 9) < 7);
      c = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom; t = 6'($urandom);
      if ($urandom_range(0, 3) == 0) b = {27'd0, b[4:0]};
      step(iv, c, a, b, t, ordy, 1'b0, model(c, a, b, t), acc, pop, o);
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_extra: got unexpected %h", o);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin failures++; $display("FAIL rand_result: got %h expected %h", o, e); end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rand_drain: got pending=%0d expected 0", exp_q.size()); end
  endtask

  // Drives the 3-stage unit directly to build a v = {1,0,1} pattern.
  task automatic test_bubble();
    res_t o, e;
    int pops;
    @(negedge clk);
    out_ready3 = 1'b1; in_valid3 = 1'b1; in_code3 = 4'(OP_ADD); in_a3 = 32'd1; in_b3 = 32'd2; in_tag3 = 6'd1;
    #1; if (in_ready3) exp_q3.push_back(model(in_code3, in_a3, in_b3, in_tag3));
    @(negedge clk);
    in_valid3 = 1'b0;
    @(negedge clk);
    in_valid3 = 1'b1; in_code3 = 4'(OP_XOR); in_a3 = 32'hA5A5_0000; in_b3 = 32'h0000_5A5A; in_tag3 = 6'd2;
    #1; if (in_ready3) exp_q3.push_back(model(in_code3, in_a3, in_b3, in_tag3));
    @(negedge clk);
    out_ready3 = 1'b0; in_code3 = 4'(OP_SLL); in_a3 = 32'h3; in_b3 = 32'h4; in_tag3 = 6'd3;
    #1;
    checks++;
    if ({out_valid3, in_ready3} !== 2'b11) begin
      failures++; $display("FAIL bubble_ready: got valid=%b ready=%b expected 1/1", out_valid3, in_ready3);
    end
    if (in_ready3) exp_q3.push_back(model(in_code3, in_a3, in_b3, in_tag3));
    @(negedge clk);
    in_code3 = 4'(OP_OR); in_tag3 = 6'd4;
    #1;
    checks++;
    if (in_ready3 !== 1'b0) begin failures++; $display("FAIL bubble_full: got %b expected 0", in_ready3); end
    pops = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      in_valid3 = 1'b0; out_ready3 = 1'b1;
      #1;
      if (out_valid3) begin
        pops++;
        o = {out_data3, out_carry3, out_ovf3, out_tag3};
        checks++;
        if (exp_q3.size() == 0) begin
          failures++; $display("FAIL bubble_extra: got unexpected %h", o);
        end else begin
          e = exp_q3.pop_front();
          if (o !== e) begin failures++; $display("FAIL bubble_result: got %h expected %h", o, e); end
        end
      end
    end
    checks++;
    if (pops != 3) begin failures++; $display("FAIL bubble_count: got %0d expected 3", pops); end
  endtask

  task automatic test_flush();
    logic acc0, acc1, pop;
    res_t o;
    int pops;
    step(1'b1, 4'(OP_ADD), 32'd7, 32'd8, 6'd20, 1'b0, 1'b0, model(4'd0, 32'd7, 32'd8, 6'd20), acc0, pop, o);
    step(1'b1, 4'(OP_SUB), 32'd9, 32'd3, 6'd21, 1'b0, 1'b0, model(4'd1, 32'd9, 32'd3, 6'd21), acc1, pop, o);
    checks++;
    if (!(acc0 && acc1)) begin failures++; $display("FAIL flush_setup: got %b%b expected 11", acc0, acc1); end
    step(1'b1, 4'(OP_OR), 32'd1, 32'd2, 6'd22, 1'b0, 1'b1, '0, acc0, pop, o);
    exp_q.delete();
    step(1'b0, 4'd0, '0, '0, '0, 1'b1, 1'b0, '0, acc0, pop, o);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    pops = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step(1'b0, 4'd0, '0, '0, '0, 1'b1, 1'b0, '0, acc0, pop, o);
      if (pop) pops++;
    end
    checks++;
    if (pops != 0) begin failures++; $display("FAIL flush_leak: got %0d results expected 0", pops); end
  endtask

  task automatic test_reset_midstream();
    logic acc, pop;
    res_t o;
    int pops;
    step(1'b1, 4'(OP_XOR), 32'hFF, 32'h0F, 6'd30, 1'b0, 1'b0, model(4'd4, 32'hFF, 32'h0F, 6'd30), acc, pop, o);
    step(1'b1, 4'(OP_ADD), 32'h80000000, 32'h80000000, 6'd31, 1'b0, 1'b0,
         model(4'd0, 32'h80000000, 32'h80000000, 6'd31), acc, pop, o);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_code = 4'(OP_OR); in_a = 32'h55; in_tag = 6'd32; out_ready = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_carry, out_ovf, out_tag} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got v=%b d=%h c=%b o=%b t=%h expected all zero",
               out_valid, out_data, out_carry, out_ovf, out_tag);
    end
    rst = 1'b1; in_valid = 1'b0;
    exp_q.delete();
    pops = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      step(1'b0, 4'd0, '0, '0, '0, 1'b1, 1'b0, '0, acc, pop, o);
      if (pop) pops++;
    end
    checks++;
    if (pops != 0) begin failures++; $display("FAIL rst_mid_leak: got %0d results expected 0", pops); end
    test_latency("rst_mid_latency");
  endtask

  initial begin
    test_reset();
    test_latency("latency");
    test_ops();
    test_back_pressure();
    test_random();
    test_bubble();
    test_flush();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipelined_int_alu.md
Name: pipelined_int_alu

Overview:
Parametrised successor to the single-cycle integer ALU. It is a multi-stage, back-pressurable integer execution unit with configurable data width and pipeline depth. It adds shifts and carry/overflow flags, and passes a tag through with each operation. It sits in the integer issue pipeline between register-read and writeback, and absorbs writeback stalls through a per-stage valid/ready pipeline that collapses bubbles.

Parameters:
DATA_WIDTH, 32, operand/result width; must be ≥ 8 and a power of two.
PIPE_STAGES, 2, number of register stages from input to output (1..4); equals the latency.
TAG_WIDTH, 6, width of the opaque tag carried alongside each op.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (rst=0 resets on the rising edge)
flush  in  1  discard every in-flight op, and any op offered in the same cycle
inValid  in  1  op offered
inReady  out  1  unit accepts the op this cycle
inCode  in  4  operation code (enum from package)
inOpA  in  DATA_WIDTH  operand A
inOpB  in  DATA_WIDTH  operand B
inTag  in  TAG_WIDTH  tag
outValid  out  1  result available
outReady  in  1  consumer takes the result
outData  out  DATA_WIDTH  result
outCarry  out  1  adder carry-out (ADD/SUB only, else 0)
outOverflow  out  1  signed overflow (ADD/SUB only, else 0)
outTag  out  TAG_WIDTH  tag of the result

Behaviour:
- Ops:
  - ADD = A+B.
  - SUB = A+~B+1; carry=1 means no borrow.
  - AND, OR, XOR.
  - SLT (signed) and SLTU: result zero-extended 0/1.
  - SLL, SRL, SRA: shift amount is B[$clog2(DATA_WIDTH)-1:0]; upper bits are ignored.
  - Undefined codes produce AND.
- Overflow = (res[msb]^a'[msb]) & (res[msb]^b'[msb]), where a' and b' are the post-inversion operands.
- Computation is combinational in front of stage 0. Stage 0 registers result, flags and tag. Stages 1..PIPE_STAGES-1 only re-register. Latency is exactly PIPE_STAGES cycles when there is no back-pressure.
- Handshake: per-stage valid bit v[k].
  - Stage k loads when !v[k] or stage k advances.
  - The last stage advances when outReady.
  - inReady = !v[0] or stage 0 advances. inReady is combinational from outReady through the pipeline.
  - A transfer occurs when inValid & inReady.
- Bubble collapse: an empty middle stage accepts from upstream even while the output is stalled.
- Full with a stall: all v=1 and outReady=0 → inReady=0. Outputs hold stable until accepted, with no data change while outValid & !outReady.
- Simultaneous output pop and input push when full: both occur and occupancy stays PIPE_STAGES.
- flush: all v cleared at the next edge. The op offered in the flush cycle is not captured, and inReady's value is irrelevant during flush. Flush has priority over load.
- Reset (rst=0): all v=0, all data/flag/tag registers=0, so outValid=0 and outData/outCarry/outOverflow/outTag=0. Reset mid-stream discards everything, and the first op after reset releases sees full latency.
- Outputs are driven directly from last-stage registers, with no combinational path from inputs to outData.

Decomposition:
- Package IntAluPkg:
  - IntAluCode enum (ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA).
  - typedef AluFlags {carry, overflow}.
  - typedef AluStage {valid, data, flags, tag}, parametrised via the module.
- Sub-module int_alu_core: purely combinational compute (adder with invert controls, logic, compare, barrel shift). The wrapper owns the stage array and handshake.

Test Plan:
1. Latency and arithmetic: PIPE_STAGES=2, ADD A=0xFFFFFFFF B=1 tag=5 with outReady held 1 → outData=0, outCarry=1, outOverflow=0, outTag=5, and outValid asserts exactly 2 cycles after acceptance.
2. Overflow and compare:
   - SUB A=0x80000000 B=1 → outData=0x7FFFFFFF, outOverflow=1, outCarry=1.
   - SLT A=0xFFFFFFFF B=0 → 1.
   - SLTU with the same operands → 0.
3. Shifts:
   - SRA A=0x80000000 B=0x21 (amount 1) → 0xC0000000.
   - SLL A=1 B=31 → 0x80000000.
   - SRL A=0x80000000 B=4 → 0x08000000.
4. Back-pressure: stream 6 ops with outReady=0.
   - inReady drops after PIPE_STAGES accepts.
   - outData stays constant while stalled.
   - After outReady is raised, all 6 results emerge in order with matching tags, none lost or duplicated.
5. Bubble collapse: with stage 0 full, the last stage full and the middle stage empty (PIPE_STAGES=3), keep outReady=0 → inReady=1 and the pipeline fills to 3.
6. Flush and reset: with 2 ops in flight, assert flush while a third is offered → outValid=0 next cycle and no results ever emerge. Repeat with rst=0 instead → all outputs 0 on the next edge.
